// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port RAM, one clock, byte-lane write enables,
// post-reset clear sequencer, deterministic same-address collision handling.
// Optional build macro: DPRAM_OUTREG_EN adds a second output register stage
// per port (dout/valid/collision latency 2 instead of 1).
//
// state  | meaning
// S_INIT | clearing mem[cnt] each cycle, ports ignored, init_busy = 1
// S_RUN  | normal two-port operation, terminal until reset
module dual_port_ram_be #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int BYTE_W   = 8,
  parameter int ADDR_BUS = $clog2(DEPTH),
  parameter int RDW_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic [WIDTH/BYTE_W-1:0] we_a,
  input  logic [ADDR_BUS-1:0]     addr_a,
  input  logic [WIDTH-1:0]        din_a,
  output logic [WIDTH-1:0]        dout_a,
  output logic                    valid_a,
  input  logic                    en_b,
  input  logic [WIDTH/BYTE_W-1:0] we_b,
  input  logic [ADDR_BUS-1:0]     addr_b,
  input  logic [WIDTH-1:0]        din_b,
  output logic [WIDTH-1:0]        dout_b,
  output logic                    valid_b,
  output logic                    init_busy,
  output logic                    collision
);
  localparam int NB = WIDTH / BYTE_W;
  localparam logic [ADDR_BUS:0]   DEPTH_W = (ADDR_BUS + 1)'(DEPTH);
  localparam logic [ADDR_BUS-1:0] LAST    = ADDR_BUS'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_BUS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic             acc_a, acc_b, inr_a, inr_b, coll_d;
  logic [WIDTH-1:0] rd_a_d, rd_b_d;
  logic [WIDTH-1:0] dout_a_q, dout_b_q;
  logic             valid_a_q, valid_b_q, coll_q;

  // Replace the lanes selected by we with the corresponding lanes of new_w.
  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]    we);
    lane_merge = old_w;
    for (int i = 0; i < NB; i++)
      if (we[i]) lane_merge[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
  endfunction

  assign init_busy = (state_q == S_INIT);
  assign acc_a     = en_a & ~init_busy;
  assign acc_b     = en_b & ~init_busy;
  assign inr_a     = ({1'b0, addr_a} < DEPTH_W);
  assign inr_b     = ({1'b0, addr_b} < DEPTH_W);
  assign coll_d    = acc_a & acc_b & (addr_a == addr_b) & ((|we_a) | (|we_b));

  // Clear sequencer next-state: walk cnt through every word, then stay in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Port A read word; out-of-range addresses read as zero. Other port's
  // write in the same cycle is never visible here (reader sees old data).
  always_comb begin
    rd_a_d = '0;
    if (inr_a) begin
      rd_a_d = mem_q[addr_a];
      if (RDW_MODE == 1) rd_a_d = lane_merge(mem_q[addr_a], din_a, we_a);
    end
  end

  // Port B read word, same rules as port A.
  always_comb begin
    rd_b_d = '0;
    if (inr_b) begin
      rd_b_d = mem_q[addr_b];
      if (RDW_MODE == 1) rd_b_d = lane_merge(mem_q[addr_b], din_b, we_b);
    end
  end

  // Memory array: clear during INIT, otherwise byte-lane writes. B is applied
  // first so that A overrides it on lanes both ports enable at one address.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (acc_b && inr_b)
        for (int i = 0; i < NB; i++)
          if (we_b[i]) mem_q[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
      if (acc_a && inr_a)
        for (int i = 0; i < NB; i++)
          if (we_a[i]) mem_q[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
    end
  end

  // FSM state, clear counter and first output stage; dout holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_a_q <= acc_a;
      valid_b_q <= acc_b;
      coll_q    <= coll_d;
      if (acc_a) dout_a_q <= rd_a_d;
      if (acc_b) dout_b_q <= rd_b_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [WIDTH-1:0] dout_a_q2, dout_b_q2;
  logic             valid_a_q2, valid_b_q2, coll_q2;

  // Second output stage: straight copy of stage one, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a_q2  <= '0;
      dout_b_q2  <= '0;
      valid_a_q2 <= 1'b0;
      valid_b_q2 <= 1'b0;
      coll_q2    <= 1'b0;
    end else begin
      dout_a_q2  <= dout_a_q;
      dout_b_q2  <= dout_b_q;
      valid_a_q2 <= valid_a_q;
      valid_b_q2 <= valid_b_q;
      coll_q2    <= coll_q;
    end
  end

  assign dout_a    = dout_a_q2;
  assign dout_b    = dout_b_q2;
  assign valid_a   = valid_a_q2;
  assign valid_b   = valid_b_q2;
  assign collision = coll_q2;
`else
  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;
  assign valid_a   = valid_a_q;
  assign valid_b   = valid_b_q;
  assign collision = coll_q;
`endif

endmodule
